// File: rtl/mem_stream_reader_pkg.sv
// mem_stream_reader_pkg
// Purpose: constants and types shared by the line-buffer read sequencer and
//          its output FIFO. The width defaults match the line-buffer BRAM.
// Contents:
//   NB_ADDRESS_DEF  default memory address width
//   RAM_WIDTH_DEF   default memory word width
//   state_t         sequencer FSM state encoding
package mem_stream_reader_pkg;

  localparam int NB_ADDRESS_DEF = 10;
  localparam int RAM_WIDTH_DEF  = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/mem_stream_reader_fifo2_skid.sv
// fifo2_skid
// Purpose: 2-entry in-order synchronous FIFO that absorbs words still in
//          flight from the memory while the downstream stalls.
// Ports:
//   i_CLK        clock, rising edge
//   i_reset      synchronous active-low reset, clears storage and count
//   i_push       write i_pushData this cycle
//   i_pushData   word to store
//   i_pop        consume the head word this cycle
//   o_headData   head word (entry 0)
//   o_headValid  FIFO holds at least one word
//   o_count      occupancy, 0..2
module fifo2_skid
  import mem_stream_reader_pkg::*;
#(
  parameter int WIDTH = RAM_WIDTH_DEF
) (
  input  logic             i_CLK,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_headData,
  output logic             o_headValid,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic [1:0]       count;
  logic             pop_ok;
  logic             push_ok;

  // A pop of an empty FIFO is ignored; a push into a full FIFO only lands
  // when the same cycle frees a slot.
  assign pop_ok  = i_pop && (count != 2'd0);
  assign push_ok = i_push && ((count != 2'd2) || pop_ok);

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_ff @(posedge i_CLK) begin
    if (!i_reset) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) entry0 <= i_pushData;
          else               entry1 <= i_pushData;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            entry0 <= i_pushData;
          end else begin
            entry0 <= entry1;
            entry1 <= i_pushData;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_headData  = entry0;
  assign o_headValid = (count != 2'd0);
  assign o_count     = count;

endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader
// Purpose: read-side sequencer for the line-buffer BRAM. A start command
//          issues consecutive addresses from a base (wrapping at the top of
//          memory), captures the words one cycle later and presents them as
//          a valid/ready stream through a 2-entry FIFO.
// Ports:
//   i_CLK       clock, rising edge
//   i_reset     synchronous active-low reset
//   i_start     start pulse, only looked at while idle
//   i_baseAdd   first address of the burst
//   i_length    number of words, 0..2^NB_ADDRESS
//   o_readAdd   memory read address
//   i_memData   memory read data (one cycle after the address)
//   o_data      stream data
//   o_valid     o_data valid
//   i_ready     downstream accepts when o_valid && i_ready
//   o_busy      burst in progress
//   o_done      one-cycle pulse after the last transfer
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter int NB_ADDRESS = NB_ADDRESS_DEF,
  parameter int RAM_WIDTH  = RAM_WIDTH_DEF
) (
  input  logic                  i_CLK,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [NB_ADDRESS-1:0] i_baseAdd,
  input  logic [NB_ADDRESS:0]   i_length,
  output logic [NB_ADDRESS-1:0] o_readAdd,
  input  logic [RAM_WIDTH-1:0]  i_memData,
  output logic [RAM_WIDTH-1:0]  o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [NB_ADDRESS-1:0] ADDR_ONE = 1;
  localparam logic [NB_ADDRESS:0]   REM_ONE  = 1;

  state_t                state;
  logic [NB_ADDRESS-1:0] addr_cnt;
  logic [NB_ADDRESS-1:0] last_add;
  logic [NB_ADDRESS:0]   remaining;
  logic                  inflight;
  logic                  done_q;
  logic [1:0]            fifo_count;
  logic                  head_valid;
  logic                  pop;
  logic [2:0]            occupancy;
  logic [2:0]            limit;
  logic                  issue;
  logic                  drain_done;

  assign pop = head_valid && i_ready;

  // A word issued this cycle is pushed at the end of the next one. By then
  // the FIFO holds fifo_count + inflight - pop words, which must leave room.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};
  assign limit     = 3'd2 + {2'b00, pop};
  assign issue     = (state == ST_RUN) && (occupancy < limit);

  // The burst is finished once nothing is in flight and this cycle's pop
  // empties the FIFO.
  assign drain_done = !inflight && (fifo_count == {1'b0, pop});

  // The address is presented during the issue cycle itself so the memory
  // samples it at the closing edge; otherwise the last issued address stays
  // on the bus.
  assign o_readAdd = issue ? addr_cnt : last_add;

  // Sequencer: latches the burst on start, walks the address counter on
  // every issue, and raises done once the last word has left the FIFO.
  always_ff @(posedge i_CLK) begin
    if (!i_reset) begin
      state     <= ST_IDLE;
      addr_cnt  <= '0;
      last_add  <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= issue;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_length != '0) begin
              state     <= ST_RUN;
              addr_cnt  <= i_baseAdd;
              remaining <= i_length;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            last_add  <= addr_cnt;
            addr_cnt  <= addr_cnt + ADDR_ONE;
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fifo2_skid #(
    .WIDTH(RAM_WIDTH)
  ) u_fifo (
    .i_CLK      (i_CLK),
    .i_reset    (i_reset),
    .i_push     (inflight),
    .i_pushData (i_memData),
    .i_pop      (pop),
    .o_headData (o_data),
    .o_headValid(head_valid),
    .o_count    (fifo_count)
  );

  assign o_valid = head_valid;
  assign o_busy  = (state != ST_IDLE);
  assign o_done  = done_q;

endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader
// Purpose: self-checking bench for mem_stream_reader with a registered,
//          read-first memory model preloaded with mem[k] = k. Expected words
//          are queued when a burst starts and a monitor pops and compares
//          them whenever the stream transfers.
module tb_mem_stream_reader;

  logic        clk;
  logic        i_reset;
  logic        i_start;
  logic [9:0]  i_baseAdd;
  logic [10:0] i_length;
  logic [9:0]  o_readAdd;
  logic [12:0] i_memData;
  logic [12:0] o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_busy;
  logic        o_done;

  logic [12:0] mem [0:1023];
  logic [12:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          xfer_cnt = 0;

  mem_stream_reader #(
    .NB_ADDRESS(10),
    .RAM_WIDTH (13)
  ) dut (
    .i_CLK    (clk),
    .i_reset  (i_reset),
    .i_start  (i_start),
    .i_baseAdd(i_baseAdd),
    .i_length (i_length),
    .o_readAdd(o_readAdd),
    .i_memData(i_memData),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  // Clock and memory model: registered read with one cycle of latency.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = 13'(k);
  end

  always @(posedge clk) i_memData <= mem[o_readAdd];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Monitor: compares every transferred word against the scoreboard.
  always @(negedge clk) begin
    if (i_reset) begin
      if (o_done) begin
        done_cnt++;
        checkOutput("busy_at_done", {31'd0, o_busy}, 32'd0);
      end
      if (o_valid && i_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word actual=%0d expected=none", o_data);
        end else begin
          checkOutput("stream_data", {19'd0, o_data}, {19'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Drives a start command and queues the words the burst must return.
  task automatic applyStimulus(input int base, input int len);
    i_baseAdd = base[9:0];
    i_length  = len[10:0];
    i_start   = 1'b1;
    for (int k = 0; k < len; k++) exp_q.push_back(13'((base + k) % 1024));
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  // Runs one burst to completion, optionally checking addresses, start
  // latency, burst duration and that a mid-burst start is ignored.
  task automatic runBurst(input int base, input int len, input logic [31:0] ready_pat,
                          input bit check_addr, input bit mid_start,
                          input int exp_cycles, input int budget);
    int cyc;
    bit seen;
    int xfer0;
    xfer0   = xfer_cnt;
    i_ready = ready_pat[0];
    applyStimulus(base, len);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) checkOutput("busy_after_start", {31'd0, o_busy}, 32'd1);
      if (exp_cycles != 0 && cyc == 2) checkOutput("valid_latency_lo", {31'd0, o_valid}, 32'd0);
      if (exp_cycles != 0 && cyc == 3) checkOutput("valid_latency_hi", {31'd0, o_valid}, 32'd1);
      if (check_addr && cyc <= len)
        checkOutput("read_addr", {22'd0, o_readAdd}, (base + cyc - 1) % 1024);
      if (o_done) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        i_ready = ready_pat[cyc % 32];
        i_start = mid_start && (cyc == 4);
        if (mid_start && cyc == 4) begin
          i_baseAdd = 10'd500;
          i_length  = 11'd3;
        end
      end
    end
    i_start = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL burst_timeout actual=%0d cycles expected=done", cyc);
    end else if (exp_cycles != 0) begin
      checkOutput("burst_cycles", cyc, exp_cycles);
    end
    checkOutput("words_out", xfer_cnt - xfer0, len);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    int x0;
    i_reset   = 1'b0;
    i_start   = 1'b0;
    i_ready   = 1'b1;
    i_baseAdd = '0;
    i_length  = '0;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b1;

    // Reset state.
    @(negedge clk);
    checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("rst_done", {31'd0, o_done}, 32'd0);
    checkOutput("rst_data", {19'd0, o_data}, 32'd0);
    checkOutput("rst_addr", {22'd0, o_readAdd}, 32'd0);

    // Base 0, length 8, always ready: 8 words, done at cycle L+3.
    d0 = done_cnt;
    runBurst(0, 8, 32'hFFFF_FFFF, 1'b1, 1'b0, 11, 100);
    repeat (2) @(negedge clk);
    checkOutput("done_pulses", done_cnt - d0, 1);
    checkOutput("idle_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("idle_valid", {31'd0, o_valid}, 32'd0);

    // Address wrap 1020 -> 1.
    runBurst(1020, 6, 32'hFFFF_FFFF, 1'b1, 1'b0, 9, 100);

    // Stalling downstream with a start attempt mid-burst; the follow-up
    // start lands in the done cycle (back-to-back).
    runBurst(40, 16, 32'hB5C3_9A6D, 1'b0, 1'b1, 0, 300);
    runBurst(300, 4, 32'hFFFF_FFFF, 1'b0, 1'b0, 7, 100);

    // Zero length: done next cycle, never busy or valid.
    i_ready = 1'b1;
    x0 = xfer_cnt;
    applyStimulus(77, 0);
    @(negedge clk);
    checkOutput("len0_done", {31'd0, o_done}, 32'd1);
    checkOutput("len0_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("len0_valid", {31'd0, o_valid}, 32'd0);
    @(negedge clk);
    checkOutput("len0_done_clear", {31'd0, o_done}, 32'd0);
    checkOutput("len0_words", xfer_cnt - x0, 0);

    // Reset mid-burst with two words buffered.
    i_ready = 1'b0;
    applyStimulus(100, 10);
    repeat (5) @(negedge clk);
    checkOutput("stall_buffered", {31'd0, o_valid}, 32'd1);
    checkOutput("stall_data", {19'd0, o_data}, 32'd100);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checkOutput("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("mid_rst_done", {31'd0, o_done}, 32'd0);
    checkOutput("mid_rst_data", {19'd0, o_data}, 32'd0);
    checkOutput("mid_rst_addr", {22'd0, o_readAdd}, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("mid_rst_valid_later", {31'd0, o_valid}, 32'd0);
    checkOutput("mid_rst_no_done", done_cnt - d0, 0);
    runBurst(5, 3, 32'hFFFF_FFFF, 1'b1, 1'b0, 6, 50);

    // Full memory sweep.
    runBurst(0, 1024, 32'hFFFF_FFFF, 1'b0, 1'b0, 1027, 1200);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
